// File: rtl/gray_pack_writer.sv
// Packs 8-bit grayscale pixels into little-endian 32-bit words and writes them via a req/ack port.
// Define GRAY_WRITER_BYTE_STROBE_EN to add the mem_strb lane-valid output.
module gray_pack_writer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        pix_in,
  input  logic              pix_valid,
  input  logic              pix_last,
  output logic              pix_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
`ifdef GRAY_WRITER_BYTE_STROBE_EN
  output logic [3:0]        mem_strb,
`endif
  output logic              frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       buf_q, buf_d;
  logic [2:0]        idx_q, idx_d;   // count of filled lanes, 0..4
  logic              last_q, last_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          buf_d   = 32'd0;
          idx_d   = 3'd0;
          last_d  = 1'b0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (pix_valid) begin
          buf_d[{idx_q[1:0], 3'b000} +: 8] = pix_in;
          idx_d  = idx_q + 3'd1;
          last_d = pix_last;
          if (idx_q[1:0] == 2'd3 || pix_last) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          addr_d  = addr_q + ADDR_W'(4);
          buf_d   = 32'd0;
          idx_d   = 3'd0;
          last_d  = 1'b0;
          state_d = last_q ? S_DONE : S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      buf_q   <= 32'd0;
      idx_q   <= 3'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign pix_ready  = (state_q == S_FILL);
  assign mem_req    = (state_q == S_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = buf_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

`ifdef GRAY_WRITER_BYTE_STROBE_EN
  // Lanes below the fill count hold pixels; idx is frozen during WRITE so strobes track wdata.
  assign mem_strb = 4'((5'd1 << idx_q) - 5'd1);
`endif

endmodule

// File: tb/tb_gray_pack_writer.sv
// Directed bench for gray_pack_writer: packing, partial words, address wrap, reset and backpressure.
module tb_gray_pack_writer;
  logic        clk, rst, start, pix_valid, pix_last, mem_ack;
  logic [15:0] base_addr;
  logic [7:0]  pix_in;
  logic        pix_ready, mem_req, busy, frame_done;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  strb_w;
  int tests = 0;
  int fails = 0;

  gray_pack_writer #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy),
`ifdef GRAY_WRITER_BYTE_STROBE_EN
    .mem_strb(strb_w),
`endif
    .frame_done(frame_done)
  );
`ifndef GRAY_WRITER_BYTE_STROBE_EN
  assign strb_w = 4'hF;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] b);
    base_addr = b; start = 1'b1; tick; start = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] d, input logic l);
    int n = 0;
    while (!pix_ready && n < 20) begin tick; n++; end
    pix_in = d; pix_valid = 1'b1; pix_last = l; tick;
    pix_valid = 1'b0; pix_last = 1'b0;
  endtask

  // Waits (bounded) for mem_req, captures the request, holds dly cycles, then acks.
  task automatic take_write(input int dly, output logic got, output logic [15:0] a,
                            output logic [31:0] d, output logic [3:0] s, output logic stable);
    int n = 0;
    got = 1'b0; stable = 1'b1; a = '0; d = '0; s = '0;
    while (!mem_req && n < 20) begin tick; n++; end
    if (mem_req) begin
      got = 1'b1; a = mem_addr; d = mem_wdata; s = strb_w;
      for (int i = 0; i < dly; i++) begin
        tick;
        if (!mem_req || mem_addr !== a || mem_wdata !== d || strb_w !== s) stable = 1'b0;
      end
      mem_ack = 1'b1; tick; mem_ack = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_last = 1'b0; mem_ack = 1'b0;
    pix_in = 8'h00; base_addr = 16'h0000;
    tick; tick;
    tests++; if ({pix_ready, mem_req, busy, frame_done} !== 4'b0000) begin fails++; $display("FAIL reset_ctrl got %b exp 0000", {pix_ready, mem_req, busy, frame_done}); end
    tests++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_data got %h/%h exp 0/0", mem_addr, mem_wdata); end
`ifdef GRAY_WRITER_BYTE_STROBE_EN
    tests++; if (strb_w !== 4'b0000) begin fails++; $display("FAIL reset_strb got %b exp 0000", strb_w); end
`endif
    rst = 1'b0; tick;
  endtask

  task automatic test_full_word;
    logic g, st; logic [15:0] a; logic [31:0] d; logic [3:0] s;
    do_start(16'h0100);
    send_pix(8'h11, 0); send_pix(8'h22, 0); send_pix(8'h33, 0); send_pix(8'h44, 0);
    take_write(2, g, a, d, s, st);
    tests++; if (g !== 1'b1 || a !== 16'h0100 || d !== 32'h44332211) begin fails++; $display("FAIL full_word got %b %h %h exp 1 0100 44332211", g, a, d); end
    tests++; if (st !== 1'b1) begin fails++; $display("FAIL full_word_stable got %b exp 1", st); end
    tests++; if (pix_ready !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 16'h0104) begin fails++; $display("FAIL after_ack got %b %b %h exp 1 0 0104", pix_ready, mem_req, mem_addr); end
    send_pix(8'hAA, 1);
    take_write(0, g, a, d, s, st);
    tests++; if (g !== 1'b1 || a !== 16'h0104 || d !== 32'h000000AA) begin fails++; $display("FAIL same_cycle_ack got %b %h %h exp 1 0104 000000aa", g, a, d); end
    tests++; if (frame_done !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL done_pulse got %b %b exp 1 1", frame_done, busy); end
    tick;
    tests++; if (frame_done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL done_end got %b %b exp 0 0", frame_done, busy); end
  endtask

  task automatic test_partial;
    logic g, st; logic [15:0] a; logic [31:0] d; logic [3:0] s;
    int pulses = 0;
    do_start(16'h0200);
    for (int i = 1; i <= 4; i++) send_pix(8'(i), 0);
    take_write(1, g, a, d, s, st);
    tests++; if (g !== 1'b1 || a !== 16'h0200 || d !== 32'h04030201) begin fails++; $display("FAIL partial_w1 got %b %h %h exp 1 0200 04030201", g, a, d); end
    send_pix(8'h05, 0); send_pix(8'h06, 1);
    take_write(1, g, a, d, s, st);
    tests++; if (g !== 1'b1 || a !== 16'h0204 || d !== 32'h00000605) begin fails++; $display("FAIL partial_w2 got %b %h %h exp 1 0204 00000605", g, a, d); end
`ifdef GRAY_WRITER_BYTE_STROBE_EN
    tests++; if (s !== 4'b0011) begin fails++; $display("FAIL partial_strb got %b exp 0011", s); end
`endif
    for (int i = 0; i < 4; i++) begin if (frame_done) pulses++; tick; end
    tests++; if (pulses != 1) begin fails++; $display("FAIL partial_done got %0d pulses exp 1", pulses); end
  endtask

  task automatic test_last_on_lane3;
    logic g, st; logic [15:0] a; logic [31:0] d; logic [3:0] s;
    int reqs = 0;
    do_start(16'h0300);
    send_pix(8'hA1, 0); send_pix(8'hA2, 0); send_pix(8'hA3, 0); send_pix(8'hA4, 1);
    take_write(0, g, a, d, s, st);
    tests++; if (g !== 1'b1 || a !== 16'h0300 || d !== 32'hA4A3A2A1) begin fails++; $display("FAIL lane3_last got %b %h %h exp 1 0300 a4a3a2a1", g, a, d); end
`ifdef GRAY_WRITER_BYTE_STROBE_EN
    tests++; if (s !== 4'b1111) begin fails++; $display("FAIL lane3_strb got %b exp 1111", s); end
`endif
    tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL lane3_done got %b exp 1", frame_done); end
    for (int i = 0; i < 6; i++) begin if (mem_req) reqs++; tick; end
    tests++; if (reqs != 0) begin fails++; $display("FAIL lane3_extra_write got %0d exp 0", reqs); end
  endtask

  task automatic test_wrap;
    logic g, st; logic [15:0] a; logic [31:0] d; logic [3:0] s;
    do_start(16'hFFFC);
    for (int i = 0; i < 4; i++) send_pix(8'h10 + 8'(i), 0);
    take_write(0, g, a, d, s, st);
    tests++; if (g !== 1'b1 || a !== 16'hFFFC || d !== 32'h13121110) begin fails++; $display("FAIL wrap_w1 got %b %h %h exp 1 fffc 13121110", g, a, d); end
    for (int i = 4; i < 8; i++) send_pix(8'h10 + 8'(i), i == 7);
    take_write(0, g, a, d, s, st);
    tests++; if (g !== 1'b1 || a !== 16'h0000 || d !== 32'h17161514) begin fails++; $display("FAIL wrap_w2 got %b %h %h exp 1 0000 17161514", g, a, d); end
    tick;
  endtask

  task automatic test_reset_mid_write;
    int reqs = 0;
    do_start(16'h0400);
    do_start(16'h0900);
    for (int i = 0; i < 4; i++) send_pix(8'h50 + 8'(i), 0);
    tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h0400) begin fails++; $display("FAIL start_in_fill got %b %h exp 1 0400", mem_req, mem_addr); end
    do_start(16'h0A00);
    tests++; if (mem_addr !== 16'h0400) begin fails++; $display("FAIL start_in_write got %h exp 0400", mem_addr); end
    rst = 1'b1; #1;
    tests++; if (mem_req !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b0) begin fails++; $display("FAIL rst_async got %b %b %b exp 0 0 0", mem_req, busy, pix_ready); end
    tests++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_async_data got %h %h exp 0 0", mem_addr, mem_wdata); end
    tick; rst = 1'b0;
    pix_valid = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin tick; if (mem_req || busy) reqs++; end
    pix_valid = 1'b0; mem_ack = 1'b0;
    tests++; if (reqs != 0) begin fails++; $display("FAIL post_rst_idle got %0d active cycles exp 0", reqs); end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  px [8];
    logic [31:0] wd [2];
    logic [15:0] wa [2];
    logic [31:0] hold_d;
    int p = 0, wc = 0, dly = 0;
    logic tog = 1'b0, viol = 1'b0, unstable = 1'b0, seen = 1'b0;
    for (int i = 0; i < 8; i++) px[i] = 8'h21 + 8'(i);
    wd[0] = '0; wd[1] = '0; wa[0] = '0; wa[1] = '0; hold_d = '0;
    do_start(16'h0500);
    for (int c = 0; c < 200 && !seen; c++) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (pix_ready) viol = 1'b1;
        if (dly == 0) begin
          hold_d = mem_wdata;
          if (wc < 2) begin wd[wc] = mem_wdata; wa[wc] = mem_addr; end
        end else if (mem_wdata !== hold_d) unstable = 1'b1;
        if (dly == 3) begin mem_ack = 1'b1; wc++; dly = 0; end
        else dly++;
      end
      tog = ~tog;
      pix_valid = tog && (p < 8);
      pix_in    = px[(p < 8) ? p : 7];
      pix_last  = (p == 7);
      if (pix_valid && pix_ready) p++;
      if (frame_done) seen = 1'b1;
      tick;
    end
    pix_valid = 1'b0; pix_last = 1'b0; mem_ack = 1'b0;
    tests++; if (p != 8 || wc != 2 || !seen) begin fails++; $display("FAIL b2b_counts got p=%0d w=%0d done=%b exp 8 2 1", p, wc, seen); end
    tests++; if (wa[0] !== 16'h0500 || wd[0] !== 32'h24232221) begin fails++; $display("FAIL b2b_w1 got %h %h exp 0500 24232221", wa[0], wd[0]); end
    tests++; if (wa[1] !== 16'h0504 || wd[1] !== 32'h28272625) begin fails++; $display("FAIL b2b_w2 got %h %h exp 0504 28272625", wa[1], wd[1]); end
    tests++; if (viol || unstable) begin fails++; $display("FAIL b2b_ready_in_write got viol=%b unstable=%b exp 0 0", viol, unstable); end
    tick; tick;
  endtask

  initial begin
    test_reset;
    test_full_word;
    test_partial;
    test_last_on_lane3;
    test_wrap;
    test_reset_mid_write;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
